// File: rtl/hv_classifier.sv
// Nearest-prototype hypervector classifier: chunked Hamming distance against NUM_CLASSES stored prototypes.
// Optional macro HV_CLASSIFIER_MARGIN_EN adds a 'margin' output (second-best minus best distance).
module hv_classifier #(
  parameter int DIMENSIONS  = 10000,
  parameter int NUM_CLASSES = 2,
  parameter int CHUNK_BITS  = 100,
  localparam int NUM_CHUNKS = DIMENSIONS / CHUNK_BITS,
  localparam int DIST_W     = $clog2(DIMENSIONS + 1),
  localparam int CLS_W      = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIMENSIONS-1:0] window_hv,
  input  logic                  in_en,
  input  logic                  proto_we,
  input  logic [CLS_W-1:0]      proto_sel,
  input  logic [DIMENSIONS-1:0] proto_hv,
  output logic                  ready,
  output logic [CLS_W-1:0]      class_out,
  output logic [DIST_W-1:0]     distance,
  output logic                  out_en,
`ifdef HV_CLASSIFIER_MARGIN_EN
  output logic [DIST_W-1:0]     margin,
`endif
  output logic                  overrun
);

  localparam int PC_W  = $clog2(CHUNK_BITS + 1);
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (DIMENSIONS % CHUNK_BITS != 0) begin : g_bad_chunk
    $error("hv_classifier: DIMENSIONS must be divisible by CHUNK_BITS");
  end
  if (NUM_CLASSES < 2) begin : g_bad_classes
    $error("hv_classifier: NUM_CLASSES must be >= 2");
  end

  function automatic logic [PC_W-1:0] popcount(input logic [CHUNK_BITS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_BITS; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t state_q, state_d;
  logic   accept, chunk_last, class_last;

  // Vectors held as chunk arrays so the per-cycle slice is a plain index.
  logic [NUM_CHUNKS-1:0][CHUNK_BITS-1:0] query_q;
  logic [NUM_CHUNKS-1:0][CHUNK_BITS-1:0] proto_q [NUM_CLASSES];

  logic [CNT_W-1:0]  chunk_q;
  logic [CLS_W-1:0]  cls_q, best_idx_q, class_out_q;
  logic [DIST_W-1:0] acc_q, dist_sum, best_q, distance_q;
  logic              out_en_q, overrun_q;
`ifdef HV_CLASSIFIER_MARGIN_EN
  logic [DIST_W-1:0] second_q, margin_q;
`endif

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    chunk_last = (int'(chunk_q) == NUM_CHUNKS - 1);
    class_last = (int'(cls_q) == NUM_CLASSES - 1);
    case (state_q)
      IDLE: if (in_en) begin
        accept  = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: if (chunk_last && class_last) state_d = DONE;
      DONE: begin
        accept  = in_en;
        state_d = in_en ? COMPARE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready    = (state_q != COMPARE);
  assign dist_sum = acc_q + DIST_W'(popcount(query_q[chunk_q] ^ proto_q[cls_q][chunk_q]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Writes land on the same edge that accepts a query, so that query sees the new prototype.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) proto_q[i] <= '0;
    end else if (proto_we && ready && (int'(proto_sel) < NUM_CLASSES)) begin
      proto_q[proto_sel] <= proto_hv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      query_q    <= '0;
      chunk_q    <= '0;
      cls_q      <= '0;
      acc_q      <= '0;
      best_q     <= '1;
      best_idx_q <= '0;
`ifdef HV_CLASSIFIER_MARGIN_EN
      second_q   <= '1;
`endif
    end else if (accept) begin
      query_q    <= window_hv;
      chunk_q    <= '0;
      cls_q      <= '0;
      acc_q      <= '0;
      best_q     <= '1;
      best_idx_q <= '0;
`ifdef HV_CLASSIFIER_MARGIN_EN
      second_q   <= '1;
`endif
    end else if (state_q == COMPARE) begin
      if (chunk_last) begin
        acc_q   <= '0;
        chunk_q <= '0;
        cls_q   <= cls_q + 1'b1;
        // Strict compare: ties keep the lower class index.
        if (dist_sum < best_q) begin
          best_q     <= dist_sum;
          best_idx_q <= cls_q;
`ifdef HV_CLASSIFIER_MARGIN_EN
          second_q   <= best_q;
        end else if (dist_sum < second_q) begin
          second_q   <= dist_sum;
`endif
        end
      end else begin
        acc_q   <= dist_sum;
        chunk_q <= chunk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_out_q <= '0;
      distance_q  <= '0;
      out_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef HV_CLASSIFIER_MARGIN_EN
      margin_q    <= '0;
`endif
    end else begin
      out_en_q <= (state_q == DONE);
      if (state_q == DONE) begin
        class_out_q <= best_idx_q;
        distance_q  <= best_q;
`ifdef HV_CLASSIFIER_MARGIN_EN
        margin_q    <= second_q - best_q;
`endif
      end
      if (in_en && (state_q == COMPARE)) overrun_q <= 1'b1;
    end
  end

  assign class_out = class_out_q;
  assign distance  = distance_q;
  assign out_en    = out_en_q;
  assign overrun   = overrun_q;
`ifdef HV_CLASSIFIER_MARGIN_EN
  assign margin    = margin_q;
`endif

endmodule

// File: tb/tb_hv_classifier.sv
// Directed bench for hv_classifier with DIMENSIONS=16, CHUNK_BITS=4, NUM_CLASSES=2 (latency 9).
module tb_hv_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] window_hv;
  logic        in_en;
  logic        proto_we;
  logic        proto_sel;
  logic [15:0] proto_hv;
  logic        ready;
  logic        class_out;
  logic [4:0]  distance;
  logic        out_en;
  logic        overrun;
`ifdef HV_CLASSIFIER_MARGIN_EN
  logic [4:0]  margin;
`endif

  int errors = 0;
  int checks = 0;

  hv_classifier #(.DIMENSIONS(16), .NUM_CLASSES(2), .CHUNK_BITS(4)) dut (
    .clk(clk), .rst(rst), .window_hv(window_hv), .in_en(in_en),
    .proto_we(proto_we), .proto_sel(proto_sel), .proto_hv(proto_hv),
    .ready(ready), .class_out(class_out), .distance(distance), .out_en(out_en),
`ifdef HV_CLASSIFIER_MARGIN_EN
    .margin(margin),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [15:0] hv);
    proto_we = 1'b1; proto_sel = sel; proto_hv = hv;
    step();
    proto_we = 1'b0;
  endtask

  // kind: 0 none, 1 in_en while busy, 2 proto write while busy, 3 back-to-back in_en in DONE
  task automatic run(input string tag, input logic [15:0] win, input int kind, input int inj_at,
                     input int exp_cls, input int exp_dist, input int exp_margin);
    int n;
    int rlow;
    window_hv = win; in_en = 1'b1;
    step();
    in_en = 1'b0; proto_we = 1'b0;
    n = 0;
    rlow = (ready == 1'b0) ? 1 : 0;
    while (!out_en && n < 20) begin
      if (n == inj_at) begin
        if (kind == 1 || kind == 3) begin in_en = 1'b1; window_hv = 16'hFFF0; end
        if (kind == 2) begin proto_we = 1'b1; proto_sel = 1'b1; proto_hv = 16'h000F; end
      end
      step();
      n++;
      if (n == inj_at + 1) begin in_en = 1'b0; proto_we = 1'b0; end
      if (n <= 8 && ready == 1'b0) rlow++;
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_ready_low"}, rlow, 8);
    check({tag, "_class"}, class_out, exp_cls);
    check({tag, "_dist"}, distance, exp_dist);
`ifdef HV_CLASSIFIER_MARGIN_EN
    check({tag, "_margin"}, margin, exp_margin);
`else
    if (exp_margin < 0) check({tag, "_margin"}, 0, 0);
`endif
    step();
    check({tag, "_pulse"}, out_en, 0);
    if (kind == 3) begin
      n = 1;
      while (!out_en && n < 20) begin
        step();
        n++;
      end
      check({tag, "_latency2"}, n, 9);
      check({tag, "_class2"}, class_out, 1);
      check({tag, "_dist2"}, distance, 4);
      check({tag, "_overrun"}, overrun, 0);
      step();
      check({tag, "_pulse2"}, out_en, 0);
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; in_en = 1'b0; proto_we = 1'b0; proto_sel = 1'b0;
    window_hv = '0; proto_hv = '0;
    step(); step();
    check("rst_ready", ready, 1);
    check("rst_out_en", out_en, 0);
    check("rst_class", class_out, 0);
    check("rst_dist", distance, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    step();

    load(1'b0, 16'h0000);
    load(1'b1, 16'hFFFF);
    run("w000f", 16'h000F, 0, -1, 0, 4, 8);
    run("wfff0", 16'hFFF0, 0, -1, 1, 4, 8);
    run("tie", 16'h00FF, 0, -1, 0, 8, 0);

    // in_en while busy: result unchanged, overrun sticks, no extra pulse
    run("busy_in", 16'h000F, 1, 3, 0, 4, 8);
    check("overrun_set", overrun, 1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_en) pulses++; end
    check("no_extra_pulse", pulses, 0);
    check("overrun_sticky", overrun, 1);

    // prototype write while busy is dropped
    run("busy_we", 16'hFFF0, 2, 3, 1, 4, 8);
    run("after_we", 16'hFFF0, 0, -1, 1, 4, 8);

    // write together with accepted in_en takes effect first
    proto_we = 1'b1; proto_sel = 1'b1; proto_hv = 16'h000F;
    run("we_with_in", 16'h000F, 0, -1, 1, 0, 4);

    // reset during COMPARE
    window_hv = 16'h000F; in_en = 1'b1;
    step();
    in_en = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("mid_rst_class", class_out, 0);
    check("mid_rst_dist", distance, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_out_en", out_en, 0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin step(); if (out_en) pulses++; end
    check("aborted_no_pulse", pulses, 0);
    run("post_rst", 16'h0003, 0, -1, 0, 2, 0);

    // back-to-back acceptance in DONE
    load(1'b1, 16'hFFFF);
    run("b2b", 16'h000F, 3, 8, 0, 4, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hv_classifier.md
Name: hv_classifier

Overview:
- Consumes one window hypervector per encoder output pulse and compares it against NUM_CLASSES stored class prototype hypervectors by Hamming distance.
- Reports the nearest class (e.g. interictal = 0, ictal = 1) with a one-cycle valid pulse.
- Sits directly downstream of lbp_encoder: window_hv/out_en feed this block's window_hv/in_en.
- Prototypes are loaded over a simple write port before or between classifications.

Parameters:
- DIMENSIONS, 10000: hypervector width in bits.
- NUM_CLASSES, 2: number of stored prototypes; must be >= 2.
- CHUNK_BITS, 100: bits compared per cycle; DIMENSIONS must be divisible by CHUNK_BITS, otherwise elaboration error.
- Derived values, not overridable:
  - NUM_CHUNKS = DIMENSIONS/CHUNK_BITS
  - DIST_W = $clog2(DIMENSIONS+1)
  - CLS_W = max(1, $clog2(NUM_CLASSES))

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- window_hv  in  DIMENSIONS  query hypervector; sampled only when in_en accepted.
- in_en  in  1  one-cycle pulse: window_hv valid.
- proto_we  in  1  prototype write strobe.
- proto_sel  in  CLS_W  prototype index to write.
- proto_hv  in  DIMENSIONS  prototype data.
- ready  out  1  high when an in_en would be accepted.
- class_out  out  CLS_W  winning class index.
- distance  out  DIST_W  Hamming distance of the winning class.
- out_en  out  1  one-cycle pulse: class_out/distance updated.
- overrun  out  1  sticky: an in_en arrived while busy.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE; all prototypes = 0; query register = 0.
  - class_out = 0, distance = 0, out_en = 0, overrun = 0, ready = 1.
  - Reset mid-COMPARE aborts the comparison; no out_en is produced.
- States:
  - IDLE: ready = 1. in_en latches window_hv into the query register, clears the chunk counter, class counter, best_dist (set to all-ones) and best_idx, then goes to COMPARE.
  - COMPARE: ready = 0. Each cycle does one chunk: popcount(query[chunk] XOR proto[class][chunk]) is added to the running accumulator.
    - After the last chunk of a class, the completed distance is compared with best_dist. It replaces best_dist and best_idx only if strictly smaller, so ties go to the lower class index.
    - The accumulator is then cleared and the class counter increments.
    - After the last chunk of the last class, go to DONE.
  - DONE: class_out/distance are loaded from best_idx/best_dist, out_en = 1 for this cycle only, and the state returns to IDLE.
    - ready = 1 in DONE. An in_en in DONE is accepted and goes straight to COMPARE.
- Latency: the edge capturing in_en is edge 0. COMPARE occupies NUM_CLASSES*NUM_CHUNKS cycles, and out_en is high in the cycle following edge NUM_CLASSES*NUM_CHUNKS+1 after capture. Defaults: 201 cycles.
- class_out/distance hold their values until the next DONE.
- in_en while ready = 0: the query is ignored, overrun is set to 1, and the comparison in progress is unaffected. overrun clears only on rst.
- proto_we: writes proto_hv into prototype proto_sel when ready = 1; ignored when ready = 0. proto_sel >= NUM_CLASSES is ignored.
- Simultaneous proto_we and accepted in_en: the write takes effect first, so the comparison uses the newly written prototype.
- Arithmetic: accumulator and distances are unsigned DIST_W bits, with no overflow possible since max = DIMENSIONS. Per-chunk popcount is $clog2(CHUNK_BITS+1) bits, zero-extended.

Optional Feature:
- Macro HV_CLASSIFIER_MARGIN_EN.
- When defined:
  - Adds output port margin (DIST_W bits) = second-smallest distance minus smallest distance, tracked alongside best_dist. A tie gives margin 0.
  - margin updates with out_en and resets to 0.
- When undefined: the port and second-best tracking logic are absent; everything else is identical.

Test Plan:
- Bench params DIMENSIONS=16, CHUNK_BITS=4, NUM_CLASSES=2 (latency 9).
- Load proto0 = 16'h0000, proto1 = 16'hFFFF; in_en with window 16'h000F -> 9 edges later out_en pulses once, class_out = 0, distance = 4, ready low for 8 cycles.
- Same prototypes, window 16'hFFF0 -> class_out = 1, distance = 4. Then window 16'h00FF (tie 8/8) -> class_out = 0, distance = 8; with HV_CLASSIFIER_MARGIN_EN, margin = 0.
- in_en pulsed at cycle 3 of a busy comparison -> overrun = 1 and stays 1; the original result is unchanged; no second out_en.
- proto_we with proto_sel = 1, data 16'h000F during COMPARE -> ignored, and the next result uses 16'hFFFF. The same write issued in IDLE together with in_en (window 16'h000F) -> class_out = 1, distance = 0.
- rst asserted at cycle 5 of COMPARE -> outputs, overrun and prototypes all 0 immediately, ready = 1, no out_en. A later window 16'h0003 gives class_out = 0, distance = 2.
- Back-to-back: in_en asserted in the DONE cycle -> accepted, overrun stays 0, second out_en exactly 9 edges later.
